// File: rtl/mem_arbiter.sv
// mem_arbiter: two-port request/acknowledge arbiter in front of the 32-word
// combinational-read data memory. Port 0 = instruction fetch, port 1 =
// load/store. One access every 3 cycles: IDLE (grant) -> ACCESS -> RESP (ack).
// Optional macro ARB_ROUND_ROBIN_EN: round-robin tie-break instead of fixed
// priority to port 1.
module mem_arbiter #(
  parameter int DW    = 32,
  parameter int AW    = 32,
  parameter int DEPTH = 32
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          req0,
  input  logic          req1,
  input  logic          we0,
  input  logic          we1,
  input  logic [AW-1:0] addr0,
  input  logic [AW-1:0] addr1,
  input  logic [DW-1:0] wdata0,
  input  logic [DW-1:0] wdata1,
  output logic          ack0,
  output logic          ack1,
  output logic          err0,
  output logic          err1,
  output logic [DW-1:0] rdata0,
  output logic [DW-1:0] rdata1,
  output logic [AW-1:0] m_ADDR,
  output logic [DW-1:0] m_DIN,
  output logic          m_en_W,
  output logic          m_en_R,
  input  logic [DW-1:0] m_R
);

  localparam logic [AW-1:0] L_DEPTH = AW'(DEPTH);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  state_t        r_state, w_next;
  logic          r_we_q, r_oob_q, r_gnt_q;
  logic [AW-1:0] r_addr_q;
  logic [DW-1:0] r_wdata_q;
  logic          w_gnt, w_take;
  logic [AW-1:0] w_addr;

`ifdef ARB_ROUND_ROBIN_EN
  logic r_ptr;  // last granted port; reset 1 so port 0 wins the first tie
  assign w_gnt = (req0 & req1) ? ~r_ptr : req1;
`else
  // Port 1 wins ties; a lone requester wins by construction.
  assign w_gnt = req1;
`endif

  assign w_take = (r_state == IDLE) & (req0 | req1);
  assign w_addr = w_gnt ? addr1 : addr0;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next;
  end

  // Next state and memory-side drive; mem sees a non-zero bus only in ACCESS
  always_comb begin
    w_next = r_state;
    m_ADDR = '0;
    m_DIN  = '0;
    m_en_W = 1'b0;
    m_en_R = 1'b0;
    case (r_state)
      IDLE:   if (req0 | req1) w_next = ACCESS;
      ACCESS: begin
        m_ADDR = r_addr_q;
        m_DIN  = r_wdata_q;
        m_en_W = r_we_q & ~r_oob_q;
        m_en_R = ~r_we_q & ~r_oob_q;
        w_next = RESP;
      end
      RESP:   w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // Latch the winner's operands at grant; later operand changes are ignored
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_we_q    <= 1'b0;
      r_oob_q   <= 1'b0;
      r_gnt_q   <= 1'b0;
      r_addr_q  <= '0;
      r_wdata_q <= '0;
    end else if (w_take) begin
      r_we_q    <= w_gnt ? we1 : we0;
      r_addr_q  <= w_addr;
      r_wdata_q <= w_gnt ? wdata1 : wdata0;
      r_oob_q   <= (w_addr >= L_DEPTH);
      r_gnt_q   <= w_gnt;
    end
  end

`ifdef ARB_ROUND_ROBIN_EN
  // Last-grant pointer, updated on every grant
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      r_ptr <= 1'b1;
    else if (w_take) r_ptr <= w_gnt;
  end
`endif

  // Ack/err pulse for RESP and read-data capture at the end of ACCESS
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ack0   <= 1'b0;
      ack1   <= 1'b0;
      err0   <= 1'b0;
      err1   <= 1'b0;
      rdata0 <= '0;
      rdata1 <= '0;
    end else begin
      ack0 <= 1'b0;
      ack1 <= 1'b0;
      err0 <= 1'b0;
      err1 <= 1'b0;
      if (r_state == ACCESS) begin
        if (r_gnt_q) begin
          ack1 <= 1'b1;
          err1 <= r_oob_q;
          if (!r_we_q) rdata1 <= r_oob_q ? '0 : m_R;
        end else begin
          ack0 <= 1'b1;
          err0 <= r_oob_q;
          if (!r_we_q) rdata0 <= r_oob_q ? '0 : m_R;
        end
      end
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed vectors for mem_arbiter with a behavioural memory.
// Build with +define+ARB_ROUND_ROBIN_EN to check the round-robin tie-break.
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req0, req1, we0, we1;
  logic [31:0] addr0, addr1, wdata0, wdata1;
  logic        ack0, ack1, err0, err1;
  logic [31:0] rdata0, rdata1;
  logic [31:0] m_ADDR, m_DIN, m_R;
  logic        m_en_W, m_en_R;

  int n_vec = 0;
  int n_err = 0;

  logic [31:0] mem [0:31];

  mem_arbiter #(.DW(32), .AW(32), .DEPTH(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0(req0), .req1(req1), .we0(we0), .we1(we1),
    .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
    .ack0(ack0), .ack1(ack1), .err0(err0), .err1(err1),
    .rdata0(rdata0), .rdata1(rdata1),
    .m_ADDR(m_ADDR), .m_DIN(m_DIN), .m_en_W(m_en_W), .m_en_R(m_en_R),
    .m_R(m_R)
  );

  always #5 clk = ~clk;

  // Behavioural mem: combinational read, garbage when not reading
  always_comb m_R = m_en_R ? mem[m_ADDR[4:0]] : 32'hBADBAD00;
  always @(posedge clk) if (m_en_W) mem[m_ADDR[4:0]] <= m_DIN;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic drive(input int port, input logic rq, input logic we,
                       input logic [31:0] addr, input logic [31:0] wd);
    if (port == 0) begin
      req0 = rq; we0 = we; addr0 = addr; wdata0 = wd;
    end else begin
      req1 = rq; we1 = we; addr1 = addr; wdata1 = wd;
    end
  endtask

  // Called from the IDLE cycle (#1 after an edge); returns in the next IDLE cycle
  task automatic xact(input string tag, input int port, input logic we,
                      input logic [31:0] addr, input logic [31:0] wd,
                      input logic exp_err, input logic [31:0] exp_rd);
    logic [1:0] exp_en;
    exp_en = exp_err ? 2'b00 : (we ? 2'b10 : 2'b01);
    drive(port, 1'b1, we, addr, wd);
    @(posedge clk); #1;  // sampling edge -> ACCESS
    chk({tag, ".en"},   {62'd0, m_en_W, m_en_R}, {62'd0, exp_en});
    chk({tag, ".addr"}, {32'd0, m_ADDR}, {32'd0, addr});
    chk({tag, ".noack"}, {62'd0, ack0, ack1}, 64'd0);
    @(posedge clk); #1;  // RESP
    chk({tag, ".ack"}, {62'd0, ack0, ack1}, (port == 0) ? 64'd2 : 64'd1);
    chk({tag, ".err"}, {62'd0, err0, err1},
        exp_err ? ((port == 0) ? 64'd2 : 64'd1) : 64'd0);
    if (!we) chk({tag, ".rdata"}, {32'd0, (port == 0) ? rdata0 : rdata1}, {32'd0, exp_rd});
    drive(port, 1'b0, 1'b0, 32'd0, 32'd0);
    @(posedge clk); #1;  // back in IDLE
    chk({tag, ".pulse"}, {62'd0, ack0, ack1}, 64'd0);
  endtask

  task automatic pulse_reset();
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  initial begin
    logic       en_seen;
    logic [3:0] exp_g;
    logic       got;
    rst_n = 1'b0;
    drive(0, 1'b0, 1'b0, 32'd0, 32'd0);
    drive(1, 1'b0, 1'b0, 32'd0, 32'd0);
    #2;
    chk("rst.ackerr", {60'd0, ack0, ack1, err0, err1}, 64'd0);
    chk("rst.rdata",  {rdata0, rdata1}, 64'd0);
    chk("rst.mbus",   {m_ADDR, m_DIN}, 64'd0);
    chk("rst.men",    {62'd0, m_en_W, m_en_R}, 64'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Idle with no requests
    en_seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      en_seen = en_seen | m_en_W | m_en_R | ack0 | ack1;
    end
    chk("idle.quiet", {63'd0, en_seen}, 64'd0);

    // Write then read back through the other port
    xact("w1_5",  1, 1'b1, 32'd5, 32'hDEADBEEF, 1'b0, 32'd0);
    xact("r0_5",  0, 1'b0, 32'd5, 32'd0,        1'b0, 32'hDEADBEEF);
    xact("w1_3",  1, 1'b1, 32'd3, 32'h33333333, 1'b0, 32'd0);
    xact("w0_7",  0, 1'b1, 32'd7, 32'h77777777, 1'b0, 32'd0);
    xact("r1_7",  1, 1'b0, 32'd7, 32'd0,        1'b0, 32'h77777777);

    // Out-of-range: read zeroes rdata, write is dropped
    xact("r0_40", 0, 1'b0, 32'd40, 32'd0,       1'b1, 32'd0);
    xact("w1_32", 1, 1'b1, 32'd32, 32'h11111111, 1'b1, 32'd0);
    xact("w1_35", 1, 1'b1, 32'd35, 32'h55555555, 1'b1, 32'd0);
    xact("r0_3",  0, 1'b0, 32'd3, 32'd0,        1'b0, 32'h33333333);
    xact("r1_5",  1, 1'b0, 32'd5, 32'd0,        1'b0, 32'hDEADBEEF);
    xact("r0_31", 0, 1'b0, 32'd31, 32'd0,       1'b0, 32'hxxxxxxxx);

    // Operand change after grant is ignored
    drive(1, 1'b1, 1'b0, 32'd3, 32'd0);
    @(posedge clk); #1;
    addr1 = 32'd7;
    chk("hold.addr", {32'd0, m_ADDR}, 64'd3);
    @(posedge clk); #1;
    chk("hold.ack",   {63'd0, ack1}, 64'd1);
    chk("hold.rdata", {32'd0, rdata1}, {32'd0, 32'h33333333});
    drive(1, 1'b0, 1'b0, 32'd0, 32'd0);
    @(posedge clk); #1;

    // Reset during ACCESS of a port 0 read, then re-service
    drive(0, 1'b1, 1'b0, 32'd5, 32'd0);
    @(posedge clk); #1;
    chk("rstmid.enR", {63'd0, m_en_R}, 64'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("rstmid.men",   {62'd0, m_en_W, m_en_R}, 64'd0);
    chk("rstmid.maddr", {32'd0, m_ADDR}, 64'd0);
    chk("rstmid.rdata", {rdata0, rdata1}, 64'd0);
    #2 rst_n = 1'b1;
    @(posedge clk); #1;
    chk("rstmid.noack", {62'd0, ack0, ack1}, 64'd0);
    chk("rstmid.reacc", {63'd0, m_en_R}, 64'd1);
    @(posedge clk); #1;
    chk("rstmid.ack",   {62'd0, ack0, ack1}, 64'd2);
    chk("rstmid.rd",    {32'd0, rdata0}, {32'd0, 32'hDEADBEEF});
    drive(0, 1'b0, 1'b0, 32'd0, 32'd0);
    @(posedge clk); #1;

    // Contention: both ports held for 4 grants from a fresh pointer
    pulse_reset();
`ifdef ARB_ROUND_ROBIN_EN
    exp_g = 4'b1010;  // grant k in bit k: 0,1,0,1
`else
    exp_g = 4'b1111;
`endif
    drive(0, 1'b1, 1'b0, 32'd3, 32'd0);
    drive(1, 1'b1, 1'b0, 32'd7, 32'd0);
    for (int k = 0; k < 4; k++) begin
      int c;
      c = 0;
      do begin
        @(posedge clk); #1;
        c++;
      end while (!(ack0 | ack1) && c < 6);
      got = ack1;
      chk($sformatf("arb.g%0d.seen", k), {63'd0, ack0 ^ ack1}, 64'd1);
      chk($sformatf("arb.g%0d", k), {63'd0, got}, {63'd0, exp_g[k]});
      if (got) chk($sformatf("arb.g%0d.rd", k), {32'd0, rdata1}, {32'd0, 32'h77777777});
      else     chk($sformatf("arb.g%0d.rd", k), {32'd0, rdata0}, {32'd0, 32'h33333333});
    end
    drive(0, 1'b0, 1'b0, 32'd0, 32'd0);
    drive(1, 1'b0, 1'b0, 32'd0, 32'd0);
    repeat (3) @(posedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
